// File: rtl/axis_arb_pkg.sv
// Shared definitions for the AXI-Stream packet arbiter: FSM encodings and
// index-width helper.
package axis_arb_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    // Width of an index into n items; never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request bit searching upward
// (with wrap) from last_grant+1.
module rr_priority_picker #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_valid
);

    logic [IDX_W-1:0] sel;

    // Walk from the farthest offset down to +1 so the nearest requester wins.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        sel         = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            sel = IDX_W'((int'(last_grant) + k) % NUM_PORTS);
            if (req[sel]) begin
                grant_idx   = sel;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-atomic round-robin arbiter merging NUM_PORTS AXI-Stream inputs into
// one egress stream tagged with the source port in tid.
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_PORTS       = 4,
    parameter int AXIS_BUS_WIDTH  = 64,
    parameter int AXIS_ID_WIDTH   = 2,
    parameter int AXIS_DEST_WIDTH = 1
) (
    input  logic                                   aclk,
    input  logic                                   aresetn,
    input  logic [NUM_PORTS*AXIS_BUS_WIDTH-1:0]    axis_in_tdata,
    input  logic [NUM_PORTS*AXIS_BUS_WIDTH/8-1:0]  axis_in_tkeep,
    input  logic [NUM_PORTS*AXIS_DEST_WIDTH-1:0]   axis_in_tdest,
    input  logic [NUM_PORTS-1:0]                   axis_in_tlast,
    input  logic [NUM_PORTS-1:0]                   axis_in_tvalid,
    output logic [NUM_PORTS-1:0]                   axis_in_tready,
    output logic [AXIS_BUS_WIDTH-1:0]              axis_out_tdata,
    output logic [AXIS_BUS_WIDTH/8-1:0]            axis_out_tkeep,
    output logic [AXIS_DEST_WIDTH-1:0]             axis_out_tdest,
    output logic                                   axis_out_tlast,
    output logic                                   axis_out_tvalid,
    output logic [AXIS_ID_WIDTH-1:0]               axis_out_tid,
    input  logic                                   axis_out_tready,
    input  logic [NUM_PORTS-1:0]                   port_enable,
    output logic [$clog2(NUM_PORTS)-1:0]           grant_idx,
    output logic                                   busy
);

    localparam int IDX_W  = idx_w(NUM_PORTS);
    localparam int KEEP_W = AXIS_BUS_WIDTH / 8;

    logic [NUM_PORTS-1:0][AXIS_BUS_WIDTH-1:0]  in_data;
    logic [NUM_PORTS-1:0][KEEP_W-1:0]          in_keep;
    logic [NUM_PORTS-1:0][AXIS_DEST_WIDTH-1:0] in_dest;

    assign in_data = axis_in_tdata;
    assign in_keep = axis_in_tkeep;
    assign in_dest = axis_in_tdest;

    logic [0:0]       state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic             eop;

    // port_enable only gates new grants; it is ignored once a packet is underway.
    rr_priority_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req         (axis_in_tvalid & port_enable),
        .last_grant  (last_grant),
        .grant_idx   (pick_idx),
        .grant_valid (pick_vld)
    );

    assign eop = axis_out_tvalid & axis_out_tready & axis_out_tlast;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            last_grant <= IDX_W'(NUM_PORTS - 1);
            grant_idx  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant_idx <= pick_idx;
                        state     <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (eop) begin
                        last_grant <= grant_idx;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy            = (state == ST_XFER);
    assign axis_out_tdata  = in_data[grant_idx];
    assign axis_out_tkeep  = in_keep[grant_idx];
    assign axis_out_tdest  = in_dest[grant_idx];
    assign axis_out_tlast  = busy & axis_in_tlast[grant_idx];
    assign axis_out_tvalid = busy & axis_in_tvalid[grant_idx];
    assign axis_out_tid    = AXIS_ID_WIDTH'(grant_idx);

    always_comb begin
        axis_in_tready = '0;
        if (busy) axis_in_tready[grant_idx] = axis_out_tready;
    end

endmodule

// File: doc/axis_packet_arbiter.md
AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- NUM_PORTS, 4: number of input streams; legal range 2..16.
- AXIS_BUS_WIDTH, 64: tdata width; multiple of 8.
- AXIS_ID_WIDTH, 2: output tid width; must be at least $clog2(NUM_PORTS).
- AXIS_DEST_WIDTH, 1: tdest width.
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- aclk, in, 1: the single clock; all logic is synchronous to it.
- aresetn, in, 1: reset, asynchronous and active-low.
- axis_in_tdata, in, NUM_PORTS*AXIS_BUS_WIDTH: packed input data; port i occupies slice i.
- axis_in_tkeep, in, NUM_PORTS*AXIS_BUS_WIDTH/8: packed byte enables.
- axis_in_tdest, in, NUM_PORTS*AXIS_DEST_WIDTH: packed destinations.
- axis_in_tlast, in, NUM_PORTS: per-port end of packet.
- axis_in_tvalid, in, NUM_PORTS: per-port valid.
- axis_in_tready, out, NUM_PORTS: per-port ready.
- axis_out_tdata / tkeep / tdest / tlast / tvalid, out, matching widths: merged egress stream.
- axis_out_tid, out, AXIS_ID_WIDTH: index of the source port, zero-extended.
- axis_out_tready, in, 1: egress ready.
- port_enable, in, NUM_PORTS: per-port arbitration eligibility.
- grant_idx, out, $clog2(NUM_PORTS): currently granted port.
- busy, out, 1: high while in XFER.

Function
REQ-003 The FSM SHALL have two states, IDLE and XFER.
REQ-004 In IDLE, the arbiter SHALL form the request vector as axis_in_tvalid & port_enable; if it is nonzero, grant the first set bit searching upward (with wrap) from last_grant+1, register grant_idx, and enter XFER on the next edge.
REQ-005 Arbitration latency SHALL be exactly one cycle: tvalid rising in IDLE leads to axis_out_tvalid in the following cycle.
REQ-006 In XFER, axis_out_tdata/tkeep/tdest/tlast/tvalid SHALL equal the granted port's signals combinationally.
REQ-007 In XFER, axis_in_tready[grant_idx] SHALL equal axis_out_tready; all other tready bits SHALL be 0. In IDLE, all tready bits and axis_out_tvalid SHALL be 0.
REQ-008 A beat with axis_out_tvalid & axis_out_tready & axis_out_tlast SHALL set last_grant to grant_idx and return the FSM to IDLE, giving one idle cycle between packets.
REQ-009 Grants SHALL be packet-atomic: no switch of source before tlast, regardless of port_enable changes or of the granted port dropping tvalid mid-packet.
REQ-010 port_enable SHALL be sampled only in IDLE; deasserting it mid-packet SHALL NOT abort the packet.
REQ-011 With all requests 0 or all ports disabled, the FSM SHALL stay in IDLE indefinitely.
REQ-012 A single-beat packet (tlast on the first beat) SHALL complete in one XFER cycle when axis_out_tready=1.
REQ-013 A port that is continuously requesting SHALL be granted within NUM_PORTS packets (fairness bound).

Reset
REQ-014 Asserting aresetn low SHALL immediately force: state=IDLE, last_grant=NUM_PORTS-1 (so port 0 wins first), grant_idx=0, busy=0, axis_out_tvalid=0, all axis_in_tready=0.
REQ-015 Reset mid-packet SHALL discard the grant; after release, arbitration SHALL restart from port 0 with no partial-beat replay.

Structure
REQ-016 The state encodings (IDLE=0, XFER=1) and an index-width helper function SHALL live in the shared package axis_arb_pkg.
REQ-017 The rotating priority search SHALL be a sub-module, rr_priority_picker (inputs: req, last_grant; outputs: grant_idx, grant_valid), which is purely combinational.
REQ-018 The top level SHALL contain only the FSM, the grant registers and the datapath muxing.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Ports 0 and 2 each present a 3-beat packet at once, tready=1 -> port 0 packet (tid=0), one idle cycle, then port 2 packet (tid=2); 7 cycles total after the first tvalid.
- All 4 ports continuously request 1-beat packets -> grant order 0,1,2,3,0,...
- Port 1 sends a 4-beat packet; port_enable[1] drops after beat 2 -> all 4 beats complete with tid=1, then port 1 is not granted again.
- axis_out_tready held 0 for 5 cycles mid-packet -> output holds beat 2 stable, no tready to other ports, and the packet resumes intact.
- aresetn pulsed low during beat 2 of a port 3 packet -> tvalid/tready drop the same cycle; after release, a port 0 request is granted first.
- port_enable=0 with all tvalid high for 20 cycles -> busy=0 and no handshakes.
